// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared NES types and cpu bus address constants
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - cpu-side and memory-map-side bus bundle around the OAM DMA
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        cpu_halt;
  logic        busy;

  modport master (
    output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    input  bus_addr, bus_d_out, bus_write, cpu_halt, busy
  );

  modport slave (
    input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    output bus_addr, bus_d_out, bus_write, cpu_halt, busy
  );

endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA: halts the cpu and copies one page to $2004
module oam_dma #(
  parameter int XFER_LEN = 256
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.slave  bus
);
  import nes_pkg::*;

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  dma_state_t w_next;
  logic [7:0] r_page;
  logic [7:0] r_count;
  logic [7:0] r_latch;
  logic       r_parity;
  logic       r_busy;
  logic       w_trigger;

  assign w_trigger = bus.cpu_write && (bus.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_parity is the current cycle; HALT goes straight to READ only when the next one is GET
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_trigger ? HALT : IDLE;
      HALT:    w_next = r_parity ? READ : ALIGN;
      ALIGN:   w_next = READ;
      READ:    w_next = WRITE;
      WRITE:   w_next = (r_count == LAST_CNT) ? IDLE : READ;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_page   <= 8'h00;
      r_count  <= 8'h00;
      r_latch  <= 8'h00;
      r_parity <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      r_busy   <= (w_next != IDLE);
      if (r_state == IDLE && w_trigger) begin
        r_page  <= bus.cpu_d_out;
        r_count <= 8'h00;
      end
      if (r_state == READ) begin
        r_latch <= bus.bus_d_in;
      end
      if (r_state == WRITE && r_count != LAST_CNT) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    bus.bus_addr  = bus.cpu_addr;
    bus.bus_d_out = bus.cpu_d_out;
    bus.bus_write = bus.cpu_write;
    case (r_state)
      HALT, ALIGN: begin
        bus.bus_d_out = 8'h00;
        bus.bus_write = 1'b0;
      end
      READ: begin
        bus.bus_addr  = {r_page, r_count};
        bus.bus_d_out = 8'h00;
        bus.bus_write = 1'b0;
      end
      WRITE: begin
        bus.bus_addr  = OAM_DATA_ADDR;
        bus.bus_d_out = r_latch;
        bus.bus_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_halt = r_busy;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed bench for oam_dma: full page, align, pass-through, wrap, reset, short build
module tb_oam_dma;
  import nes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  mem [0:65535];
  logic        tb_par;

  int n_checks = 0;
  int n_fail   = 0;

  oam_dma_if bus0 ();
  oam_dma_if bus4 ();

  assign bus0.cpu_addr  = cpu_addr;
  assign bus0.cpu_d_out = cpu_d_out;
  assign bus0.cpu_write = cpu_write;
  assign bus0.bus_d_in  = mem[bus0.bus_addr];
  assign bus4.cpu_addr  = cpu_addr;
  assign bus4.cpu_d_out = cpu_d_out;
  assign bus4.cpu_write = cpu_write;
  assign bus4.bus_d_in  = mem[bus4.bus_addr];

  oam_dma #(.XFER_LEN(256)) dut  (.clk(clk), .rst(rst), .bus(bus0));
  oam_dma #(.XFER_LEN(4))   dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // GET/PUT reference parity: 0 in the first cycle after release, toggling every clock
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  int          halt_cnt, halt_wr_bad, wr_addr_bad, wr4, halt4;
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  logic [7:0]  wr4_last;

  always @(negedge clk) begin
    if (bus0.cpu_halt) halt_cnt++;
    if (bus0.cpu_halt && !bus0.bus_write && bus0.bus_addr != cpu_addr) rd_q.push_back(bus0.bus_addr);
    if (bus0.cpu_halt && bus0.bus_write) begin
      wr_q.push_back(bus0.bus_d_out);
      if (bus0.bus_addr != OAM_DATA_ADDR) wr_addr_bad++;
      if (bus0.bus_addr == cpu_addr) halt_wr_bad++;
    end
    if (bus4.cpu_halt) halt4++;
    if (bus4.cpu_halt && bus4.bus_write) begin
      wr4++;
      wr4_last = bus4.bus_d_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    halt_cnt = 0; halt_wr_bad = 0; wr_addr_bad = 0; wr4 = 0; halt4 = 0; wr4_last = 8'h00;
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic trigger(input logic [7:0] page, input logic want_par);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (tb_par != want_par && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    cpu_addr = DMA_REG_ADDR; cpu_d_out = page; cpu_write = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_d_out = 8'h00; cpu_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus0.busy && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus0.busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_page02(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] != (8'(i) ^ 8'hA5)) errs++;
    chk({tag, "_nwr"}, wr_q.size(), 256);
    chk({tag, "_data_err"}, errs, 0);
    chk({tag, "_wr_addr_bad"}, wr_addr_bad, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0300 + i] = 8'h77;
      mem[16'hFF00 + i] = 8'(i);
    end
    cpu_addr = 16'hBEEF; cpu_d_out = 8'h11; cpu_write = 1'b1;
    clear_mon();
    #12;
    chk("rst_busy", {31'd0, bus0.busy}, 0);
    chk("rst_halt", {31'd0, bus0.cpu_halt}, 0);
    chk("rst_addr", bus0.bus_addr, 16'hBEEF);
    chk("rst_write", {31'd0, bus0.bus_write}, 1);
    cpu_write = 1'b0; cpu_addr = 16'h1234;
    @(negedge clk); rst = 1'b1;

    // 1: basic copy, HALT directly followed by GET
    clear_mon();
    trigger(8'h02, 1'b0);
    wait_idle("t1_idle");
    chk("t1_rd0", rd_q.size() > 0 ? rd_q[0] : 16'hDEAD, 16'h0200);
    chk("t1_wr0", wr_q.size() > 0 ? wr_q[0] : 8'h00, 8'hA5);
    chk("t1_wr_last", wr_q.size() == 256 ? wr_q[255] : 8'h00, 8'h5A);
    chk("t1_halt", halt_cnt, 513);
    check_page02("t1");

    // 2: alignment cycle inserted
    clear_mon();
    trigger(8'h02, 1'b1);
    wait_idle("t2_idle");
    chk("t2_halt", halt_cnt, 514);
    chk("t2_halt_wr", halt_wr_bad, 0);
    check_page02("t2");

    // 3: pass-through while idle
    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_d_out = 8'h3C; cpu_write = 1'b1;
    @(negedge clk);
    chk("t3_w_addr", bus0.bus_addr, 16'h4015);
    chk("t3_w_data", bus0.bus_d_out, 8'h3C);
    chk("t3_w_wr", {31'd0, bus0.bus_write}, 1);
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_d_out = 8'h00; cpu_write = 1'b0;
    @(negedge clk);
    chk("t3_r_addr", bus0.bus_addr, 16'h8000);
    chk("t3_r_wr", {31'd0, bus0.bus_write}, 0);
    chk("t3_busy", {30'd0, bus0.busy, bus0.cpu_halt}, 0);
    @(posedge clk); #1;
    cpu_addr = 16'h1234;

    // 4: page $FF wraps within the page
    clear_mon();
    trigger(8'hFF, 1'b0);
    wait_idle("t4_idle");
    bad = 0;
    foreach (rd_q[i]) if (rd_q[i][15:8] != 8'hFF) bad++;
    chk("t4_nrd", rd_q.size(), 256);
    chk("t4_rd0", rd_q.size() > 0 ? rd_q[0] : 16'hDEAD, 16'hFF00);
    chk("t4_rd_last", rd_q.size() == 256 ? rd_q[255] : 16'hDEAD, 16'hFFFF);
    chk("t4_rd_page", bad, 0);
    chk("t4_wr_last", wr_q.size() == 256 ? wr_q[255] : 8'h00, 8'hFF);

    // 5: reset during the WRITE of byte 100
    clear_mon();
    trigger(8'h02, 1'b0);
    bad = 0;
    while (wr_q.size() < 101 && bad < 400) begin
      @(negedge clk); #1;
      bad++;
    end
    chk("t5_reach", wr_q.size(), 101);
    rst = 1'b0;
    #1;
    chk("t5_halt", {31'd0, bus0.cpu_halt}, 0);
    chk("t5_busy", {31'd0, bus0.busy}, 0);
    chk("t5_wr", {31'd0, bus0.bus_write}, 0);
    chk("t5_addr", bus0.bus_addr, 16'h1234);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_more_wr", wr_q.size(), 101);
    clear_mon();
    trigger(8'h02, 1'b0);
    wait_idle("t5_idle");
    chk("t5_rd0", rd_q.size() > 0 ? rd_q[0] : 16'hDEAD, 16'h0200);
    check_page02("t5");

    // 6a: $4014 write while busy is ignored
    clear_mon();
    trigger(8'h02, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    cpu_addr = DMA_REG_ADDR; cpu_d_out = 8'h03; cpu_write = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_d_out = 8'h00; cpu_write = 1'b0;
    wait_idle("t6_idle");
    check_page02("t6");
    chk("t6_halt", halt_cnt, 513);
    repeat (5) @(negedge clk);
    chk("t6_still_idle", {31'd0, bus0.busy}, 0);

    // 6b: XFER_LEN=4 build
    clear_mon();
    trigger(8'h02, 1'b0);
    wait_idle("t6b_idle0");
    chk("t6b_nwr", wr4, 4);
    chk("t6b_halt9", halt4, 9);
    chk("t6b_last", wr4_last, 8'hA6);
    clear_mon();
    trigger(8'h02, 1'b1);
    wait_idle("t6b_idle1");
    chk("t6b_nwr_al", wr4, 4);
    chk("t6b_halt10", halt4, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-OAM DMA engine on the cpu's external bus, between the cpu's addr/d_out/write pins and the system memory map.
- A cpu write to $4014 triggers it. It halts the cpu and copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port $2004, alternating read and write cycles.
- When idle it passes cpu bus signals through unchanged.

Parameters:
- DMA_REG_ADDR, 16'h4014, cpu address that triggers a transfer; written data byte = source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- clk  input  1  system clock, cpu cycle rate.
- rst  input  1  asynchronous, active-low reset.
- cpu_addr  input  16  cpu address bus.
- cpu_d_out  input  8  cpu write data.
- cpu_write  input  1  cpu write strobe.
- bus_d_in  input  8  read data from memory map; combinational, valid in the same cycle as bus_addr.
- bus_addr  output  16  address to memory map.
- bus_d_out  output  8  write data to memory map.
- bus_write  output  1  write strobe to memory map.
- cpu_halt  output  1  high = cpu must not advance state, PC or drive the bus.
- busy  output  1  high from trigger through the last DMA write.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, cpu_halt=0, busy=0.
  - page, byte count, data latch and parity flop = 0.
  - Bus outputs in pass-through: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_write=cpu_write.
- Parity flop toggles every clock from reset release. 0 = GET cycle, 1 = PUT cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Bus is pass-through.
  - If cpu_write && cpu_addr==DMA_REG_ADDR: latch page<=cpu_d_out, count<=0, next=HALT.
  - The triggering write itself still passes through to the bus.
- HALT (1 cycle, dummy):
  - cpu_halt=1, busy=1.
  - Bus driven idle: bus_addr=cpu_addr, bus_write=0, bus_d_out=8'h00.
  - Next=READ if the next cycle is GET, otherwise ALIGN.
- ALIGN (0 or 1 cycle): same bus outputs as HALT; next=READ.
- READ (always a GET cycle):
  - bus_addr={page,count}, bus_write=0.
  - Data latch <= bus_d_in at the end of the cycle.
  - Next=WRITE.
- WRITE (always a PUT cycle):
  - bus_addr=OAM_DATA_ADDR, bus_d_out=latch, bus_write=1.
  - If count==XFER_LEN-1: next=IDLE. Otherwise count<=count+1, next=READ.
- cpu_halt and busy are registered, high exactly in HALT/ALIGN/READ/WRITE. They drop on the cycle IDLE is re-entered.
- Total halt for XFER_LEN=256: 513 cycles if HALT lands such that READ follows directly, 514 if ALIGN is inserted.
- Width rules:
  - count is 8 bits. Source address wraps within the page and never carries into the page byte.
  - Page $FF is legal: reads $FF00-$FFFF.
- Cpu writes are ignored while busy. A $4014 write during a transfer does not restart or re-latch the page; the cpu is halted anyway.
- Reset mid-transfer: immediate abort to IDLE, cpu_halt=0. No further bus_write is issued; the partial copy stays in OAM.
- Source page in the $2000-$3FFF or $4000-$4017 register space is not special-cased. Reads go out on the bus as-is.

Decomposition:
- Shared package nes_pkg:
  - dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE).
  - Address constants DMA_REG_ADDR and OAM_DATA_ADDR, also used by the PPU register decoder.
- No sub-module. The pass-through mux is a single always_comb in this block.
- The top level wires the cpu halt input to cpu_halt. The cpu gates its PC increment and state advance on it, alongside the existing internal hold.

Test Plan:
1. Basic copy, no ALIGN.
   - Stimulus: preload RAM $0200+i = i^8'hA5 for i=0..255. Trigger with cpu write $02 to $4014 so HALT is followed by a GET cycle.
   - Response: no ALIGN. First READ addr=16'h0200; first WRITE addr=16'h2004 data=8'hA5; last WRITE data=8'h5A. cpu_halt high exactly 513 cycles.
2. Alignment.
   - Stimulus: same transfer triggered one cycle later.
   - Response: ALIGN present. cpu_halt high exactly 514 cycles. bus_write stays 0 in HALT/ALIGN.
3. Pass-through.
   - Stimulus: idle; cpu writes 8'h3C to $4015, then reads $8000.
   - Response: bus mirrors cpu signals in the same cycle. busy=0, cpu_halt=0.
4. Page wrap.
   - Stimulus: trigger with page $FF.
   - Response: READ addresses run $FF00..$FFFF. The final READ is $FFFF, never $0000.
5. Reset mid-transfer.
   - Stimulus: assert rst low during the WRITE of byte 100.
   - Response: cpu_halt=0 and bus pass-through immediately, with no clock edge needed. After release, a new trigger restarts from byte 0.
6. Retrigger and short transfer.
   - Stimulus: $4014 write while busy; separately, a build with XFER_LEN=4.
   - Response: the write while busy is ignored and the original page finishes. The XFER_LEN=4 build does exactly 4 WRITEs; halt lasts 9 or 10 cycles.
